// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read channel: the fetch unit is the master and raises a request;
// the memory answers with ack and data.
interface instr_fetch_unit_if;
    logic        IMemReq;
    logic [15:0] IMemAddr;
    logic        IMemAck;
    logic [15:0] IMemData;

    modport master (output IMemReq, output IMemAddr, input IMemAck, input IMemData);
    modport slave  (input IMemReq, input IMemAddr, output IMemAck, output IMemData);
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch/issue front end of the 16-bit CPU: owns PC and IR and feeds ControlUnit.
// Optional macro PERF_COUNT_EN adds a saturating RetiredCount output.
module instr_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int unsigned PC_STEP  = 2
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Enable,
    instr_fetch_unit_if.master  imem,
    output logic [2:0]          OPCODE,
    output logic [1:0]          RS,
    output logic [1:0]          RT,
    output logic [1:0]          RD,
    output logic [15:0]         IMM,
    output logic                InstrValid,
    input  logic                Branch,
    input  logic                Zero,
    output logic [15:0]         PC
`ifdef PERF_COUNT_EN
    ,
    output logic [15:0]         RetiredCount
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_pc;
    logic [15:0] r_ir;
    logic [15:0] w_pc_next;
    logic        w_req;
    logic        w_valid;

    always_comb begin
        w_next  = r_state;
        w_req   = 1'b0;
        w_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (Enable) w_next = S_FETCH;
            end
            S_FETCH: begin
                w_req = 1'b1;
                if (imem.IMemAck) w_next = S_ISSUE;
            end
            S_ISSUE: begin
                w_valid = 1'b1;
                w_next  = Enable ? S_FETCH : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Sign-extended immediate is a word offset, hence the shift before adding.
    assign w_pc_next = (Branch & Zero) ? (r_pc + 16'(PC_STEP) + (IMM << 1))
                                       : (r_pc + 16'(PC_STEP));

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_ir    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_FETCH && imem.IMemAck) r_ir <= imem.IMemData;
            if (r_state == S_ISSUE) r_pc <= w_pc_next;
        end
    end

`ifdef PERF_COUNT_EN
    logic [15:0] r_retired;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_retired <= '0;
        end else if (r_state == S_ISSUE && r_retired != 16'hFFFF) begin
            r_retired <= r_retired + 16'd1;
        end
    end

    assign RetiredCount = r_retired;
`endif

    assign imem.IMemReq  = w_req;
    assign imem.IMemAddr = r_pc;
    assign InstrValid    = w_valid;
    assign PC            = r_pc;
    assign OPCODE        = r_ir[15:13];
    assign RS            = r_ir[12:11];
    assign RT            = r_ir[10:9];
    assign RD            = r_ir[8:7];
    assign IMM           = {{8{r_ir[7]}}, r_ir[7:0]};

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a behavioural model predicts each cycle's
// observable state; a negedge monitor pops and compares.
module tb_instr_fetch_unit;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Enable = 1'b0;
    logic        Branch = 1'b0;
    logic        Zero = 1'b0;
    logic [2:0]  OPCODE;
    logic [1:0]  RS, RT, RD;
    logic [15:0] IMM;
    logic        InstrValid;
    logic [15:0] PC;
`ifdef PERF_COUNT_EN
    logic [15:0] RetiredCount;
`endif

    instr_fetch_unit_if imem_if();

    instr_fetch_unit #(.RESET_PC(16'h0000), .PC_STEP(2)) dut (
        .Clock(Clock),
        .Reset(Reset),
        .Enable(Enable),
        .imem(imem_if),
        .OPCODE(OPCODE),
        .RS(RS),
        .RT(RT),
        .RD(RD),
        .IMM(IMM),
        .InstrValid(InstrValid),
        .Branch(Branch),
        .Zero(Zero),
        .PC(PC)
`ifdef PERF_COUNT_EN
        ,
        .RetiredCount(RetiredCount)
`endif
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic        req;
        logic        valid;
        logic [15:0] pc;
        logic [15:0] ir;
        logic [15:0] ret;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: what the CPU front end is doing this cycle, in plain terms.
    logic        m_fetching = 1'b0;
    logic        m_issuing  = 1'b0;
    logic [15:0] m_pc  = 16'h0000;
    logic [15:0] m_ir  = 16'h0000;
    logic [15:0] m_ret = 16'h0000;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
        end
    endtask

    always @(negedge Clock) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [15:0] sext;
            e = exp_q.pop_front();
            sext = {{8{e.ir[7]}}, e.ir[7:0]};
            chk("IMemReq", 16'(imem_if.IMemReq), 16'(e.req));
            chk("InstrValid", 16'(InstrValid), 16'(e.valid));
            if (e.req) chk("IMemAddr", imem_if.IMemAddr, e.pc);
            chk("PC", PC, e.pc);
            chk("OPCODE", 16'(OPCODE), 16'(e.ir[15:13]));
            chk("RS", 16'(RS), 16'(e.ir[12:11]));
            chk("RT", 16'(RT), 16'(e.ir[10:9]));
            chk("RD", 16'(RD), 16'(e.ir[8:7]));
            chk("IMM", IMM, sext);
`ifdef PERF_COUNT_EN
            chk("RetiredCount", RetiredCount, e.ret);
`endif
        end
    end

    // One clock of stimulus: record what the model says is visible now, drive inputs,
    // then advance the model to what the next edge should produce.
    task automatic step(input logic en, input logic ack, input logic [15:0] data,
                        input logic br, input logic z, input logic rst);
        exp_t e;
        @(posedge Clock);
        #1;
        e.req = m_fetching; e.valid = m_issuing; e.pc = m_pc; e.ir = m_ir; e.ret = m_ret;
        exp_q.push_back(e);
        Enable = en;
        imem_if.IMemAck = ack;
        imem_if.IMemData = data;
        Branch = br;
        Zero = z;
        Reset = rst;
        if (rst) begin
            m_fetching = 1'b0; m_issuing = 1'b0;
            m_pc = 16'h0000; m_ir = 16'h0000; m_ret = 16'h0000;
        end else if (m_issuing) begin
            int signed off;
            off = int'($signed(m_ir[7:0])) * 2;
            m_pc = (br && z) ? 16'(int'(m_pc) + 2 + off) : 16'(int'(m_pc) + 2);
            if (m_ret != 16'hFFFF) m_ret = m_ret + 16'd1;
            m_issuing = 1'b0;
            m_fetching = en;
        end else if (m_fetching) begin
            if (ack) begin
                m_ir = data;
                m_fetching = 1'b0;
                m_issuing = 1'b1;
            end
        end else begin
            m_fetching = en;
        end
    endtask

    // Fetch one instruction (model must be fetching) after dly wait cycles, then issue it.
    task automatic instr(input logic [15:0] data, input logic br, input logic z,
                         input int unsigned dly, input logic en);
        for (int unsigned i = 0; i < dly; i++) step(en, 1'b0, 16'hDEAD, 1'b1, 1'b1, 1'b0);
        step(en, 1'b1, data, 1'b1, 1'b1, 1'b0);
        step(en, 1'b1, 16'hBEEF, br, z, 1'b0);
    endtask

    initial begin
        imem_if.IMemAck = 1'b0;
        imem_if.IMemData = 16'h0000;

        step(1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 16'h1234, 1'b1, 1'b1, 1'b0);

        instr(16'h4000, 1'b0, 1'b0, 0, 1'b1);
        instr(16'h4000, 1'b0, 1'b0, 0, 1'b1);
        instr(16'h4000, 1'b0, 1'b0, 0, 1'b1);
        instr(16'h4000, 1'b0, 1'b0, 3, 1'b1);
        instr(16'h0003, 1'b1, 1'b1, 0, 1'b1);   // 0008 -> 0010
        instr(16'h00FE, 1'b1, 1'b1, 1, 1'b1);   // 0010 -> 000E
        instr(16'h00FE, 1'b1, 1'b0, 0, 1'b1);   // 000E -> 0010
        instr(16'h00F6, 1'b1, 1'b1, 0, 1'b1);   // 0010 -> FFFE
        instr(16'hA5A5, 1'b0, 1'b1, 2, 1'b1);   // FFFE -> 0000

        step(1'b1, 1'b1, 16'hA5A5, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 16'h5A5A, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 5; i++) instr(16'(32'h2000 + i), 1'b0, 1'b0, i % 3, 1'b1);
        instr(16'hE0FF, 1'b1, 1'b1, 2, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'h7777, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)), 16'($urandom),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 199) == 0);
        end

        @(negedge Clock);
        @(negedge Clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
